dcache_req_responder: RTL and testbench

//  Responder end of the exe-stage data request interface (data_valid/data_addr_ok).

---
 rtl/dcache_req_responder.sv | 164 ++++++++++++++++
 tb/tb_dcache_req_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_responder.sv
// dcache_req_responder: in-order request queue that issues one word-wide memory access at a time.
// Latency: accept T, mem_req T+1, data_data_ok with mem_rvalid (one cycle later when DREQ_RESP_REG_EN).
// Backpressure: data_addr_ok drops while the queue is full; mem_req is held until mem_gnt.
module dcache_req_responder #(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_valid,
    input  logic        data_op,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic [31:0] data_addr,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        op;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [29:0] word_addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    req_t          queue_q [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    req_t          head;
    logic          push;
    logic          pop;
    logic [31:0]   resp_dat;
    logic          unused_addr_lsb;

    // The memory port is word-wide; byte offset only matters to the requester.
    assign unused_addr_lsb = ^data_addr[1:0];

    assign data_addr_ok = (count_q != CW'(QUEUE_DEPTH));
    assign push         = data_valid && data_addr_ok;
    assign pop          = (state_q == ST_WAIT) && mem_rvalid;
    assign head         = queue_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                queue_q[wr_ptr_q] <= '{op:        data_op,
                                       size:      data_size,
                                       wstrb:     data_wstrb,
                                       word_addr: data_addr[31:2],
                                       wdata:     data_wdata};
            end
        end
    end

    // Next-state looks at count_d so a push this cycle raises mem_req next cycle,
    // and a pop with entries still queued reissues without an idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req && head.op;
    assign mem_size  = mem_req ? head.size : 3'd0;
    assign mem_wstrb = mem_we  ? head.wstrb : 4'd0;
    assign mem_addr  = mem_req ? {head.word_addr, 2'b00} : 32'd0;
    assign mem_wdata = mem_we  ? head.wdata : 32'd0;

    // Stores complete with a write ack; whatever is on mem_rdata then is not data.
    assign resp_dat = (pop && !head.op) ? mem_rdata : 32'd0;

`ifdef DREQ_RESP_REG_EN
    logic        resp_vld_q, resp_vld_d;
    logic [31:0] resp_dat_q, resp_dat_d;

    assign resp_vld_d = pop;
    assign resp_dat_d = resp_dat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_vld_q <= 1'b0;
            resp_dat_q <= 32'd0;
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
        end
    end

    assign data_data_ok = resp_vld_q;
    assign data_rdata   = resp_dat_q;
`else
    assign data_data_ok = pop;
    assign data_rdata   = resp_dat;
`endif

endmodule

// File: tb/tb_dcache_req_responder.sv
// Bench for dcache_req_responder: directed vector table, hand-written queue/reset sequences,
// and randomized traffic scored against a queue-based model of the request/response contract.
module tb_dcache_req_responder;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_valid;
    logic        data_op;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dcache_req_responder #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .data_valid(data_valid), .data_op(data_op), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr(data_addr),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        op;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        rq;
        logic [31:0] rdata;
        logic [31:0] x_addr;
        logic        x_we;
        logic [3:0]  x_wstrb;
        logic [31:0] x_rdata;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          occ;
    bit          busy;
    int          lat;
    logic [31:0] rd_val;
    req_t        send_q[$];
    req_t        issue_q[$];
    logic [31:0] resp_q[$];
    int          plan_q[$];
    vec_t        vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input req_t r);
        data_valid = 1'b1;
        data_op    = r.op;
        data_size  = r.size;
        data_wstrb = r.wstrb;
        data_wdata = r.wdata;
        data_addr  = r.addr;
    endtask

    task automatic idle_inputs();
        data_valid = 1'b0; data_op = 1'b0; data_size = 3'd0; data_wstrb = 4'd0;
        data_wdata = 32'd0; data_addr = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    function automatic req_t mk_req(input logic op, input logic [2:0] size, input logic [3:0] wstrb,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.op = op; r.size = size; r.wstrb = wstrb; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic vec_t mk_vec(input req_t rq, input logic [31:0] rdata, input logic [31:0] x_addr,
                                    input logic x_we, input logic [3:0] x_wstrb, input logic [31:0] x_rdata);
        vec_t v;
        v.rq = rq; v.rdata = rdata; v.x_addr = x_addr; v.x_we = x_we; v.x_wstrb = x_wstrb;
        v.x_rdata = x_rdata;
        return v;
    endfunction

    function automatic req_t rand_req();
        return mk_req(1'($urandom_range(1)), 3'($urandom_range(2)), 4'($urandom), $urandom, $urandom);
    endfunction

    task automatic clear_model();
        send_q.delete(); issue_q.delete(); resp_q.delete(); plan_q.delete();
        occ = 0; busy = 1'b0; lat = 0; rd_val = 32'd0;
    endtask

    // One clock of randomized traffic: requester, memory model, then scoreboard at negedge.
    task automatic auto_cycle(input int vpct);
        req_t e;
        step();
        if (send_q.size() != 0 && $urandom_range(99) < vpct) begin
            drive_req(send_q[0]);
        end else begin
            drive_req(rand_req());
            data_valid = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (busy) begin
            if (lat == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_val;
                busy       = 1'b0;
            end else begin
                lat--;
            end
        end else if (mem_req && (plan_q.size() != 0 || $urandom_range(2) != 0)) begin
            mem_gnt = 1'b1;
            busy    = 1'b1;
            lat     = (plan_q.size() != 0) ? plan_q.pop_front() : int'($urandom_range(2));
            rd_val  = $urandom;
            if (issue_q.size() == 0) begin
                chk1("issue_unexpected", mem_req, 1'b0);
            end else begin
                e = issue_q.pop_front();
                chk("iss_addr", mem_addr, {e.addr[31:2], 2'b00});
                chk1("iss_we", mem_we, e.op);
                chk("iss_wstrb", 32'(mem_wstrb), e.op ? 32'(e.wstrb) : 32'd0);
                chk("iss_size", 32'(mem_size), 32'(e.size));
                if (e.op) chk("iss_wdata", mem_wdata, e.wdata);
                resp_q.push_back(e.op ? 32'd0 : rd_val);
            end
        end
        @(negedge clk);
        chk1("addr_ok_model", data_addr_ok, occ != DEPTH);
        if (data_valid && data_addr_ok) begin
            issue_q.push_back(send_q.pop_front());
            occ++;
        end
        if (mem_rvalid) occ--;
        chk1("occ_bound", occ <= DEPTH, 1'b1);
        if (resp_q.size() == 0) begin
            chk1("resp_unexpected", data_data_ok, 1'b0);
        end else if (data_data_ok) begin
            chk("resp_rdata", data_rdata, resp_q.pop_front());
        end
    endtask

    task automatic run_traffic(input int vpct, input int limit, input string name);
        int n = 0;
        while ((send_q.size() != 0 || issue_q.size() != 0 || resp_q.size() != 0 || busy) && n < limit) begin
            auto_cycle(vpct);
            n++;
        end
        chk1(name, n < limit, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        clear_model();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk1("rst_addr_ok", data_addr_ok, 1'b1);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_data_ok", data_data_ok, 1'b0);
        chk("rst_rdata", data_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);

        // Single transactions with immediate grant and one-cycle memory latency.
        vt[0] = mk_vec(mk_req(1'b0, 3'd1, 4'b0000, 32'h1000_0006, 32'h0), 32'hA5A5_1234,
                       32'h1000_0004, 1'b0, 4'b0000, 32'hA5A5_1234);
        vt[1] = mk_vec(mk_req(1'b1, 3'd2, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF), 32'h1234_5678,
                       32'h0000_0020, 1'b1, 4'b1100, 32'h0);
        vt[2] = mk_vec(mk_req(1'b0, 3'd0, 4'b0000, 32'h0000_0003, 32'h0), 32'hDEAD_BEEF,
                       32'h0000_0000, 1'b0, 4'b0000, 32'hDEAD_BEEF);
        vt[3] = mk_vec(mk_req(1'b1, 3'd0, 4'b1000, 32'hFFFF_FFFF, 32'h1111_1111), 32'hFFFF_FFFF,
                       32'hFFFF_FFFC, 1'b1, 4'b1000, 32'h0);
        vt[4] = mk_vec(mk_req(1'b0, 3'd2, 4'b1111, 32'h8000_0010, 32'h5555_5555), 32'h0F0F_0F0F,
                       32'h8000_0010, 1'b0, 4'b0000, 32'h0F0F_0F0F);
        for (int i = 0; i < 5; i++) begin
            step();
            drive_req(vt[i].rq);
            @(negedge clk);
            chk1("v_accept", data_addr_ok, 1'b1);
            chk1("v_idle_req", mem_req, 1'b0);
            step();
            data_valid = 1'b0;
            mem_gnt    = 1'b1;
            @(negedge clk);
            chk1("v_req", mem_req, 1'b1);
            chk("v_addr", mem_addr, vt[i].x_addr);
            chk1("v_we", mem_we, vt[i].x_we);
            chk("v_wstrb", 32'(mem_wstrb), 32'(vt[i].x_wstrb));
            chk("v_size", 32'(mem_size), 32'(vt[i].rq.size));
            if (vt[i].x_we) chk("v_wdata", mem_wdata, vt[i].rq.wdata);
            chk1("v_ok_early", data_data_ok, 1'b0);
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = vt[i].rdata;
            @(negedge clk);
            chk1("v_wait_req", mem_req, 1'b0);
`ifdef DREQ_RESP_REG_EN
            chk1("v_ok_t2", data_data_ok, 1'b0);
`else
            chk1("v_ok_t2", data_data_ok, 1'b1);
            chk("v_rdata", data_rdata, vt[i].x_rdata);
`endif
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0BAD_0BAD;
            @(negedge clk);
`ifdef DREQ_RESP_REG_EN
            chk1("v_ok_t3", data_data_ok, 1'b1);
            chk("v_rdata", data_rdata, vt[i].x_rdata);
`else
            chk1("v_ok_t3", data_data_ok, 1'b0);
`endif
            chk1("v_back_idle", mem_req, 1'b0);
        end

        // Queue full: three loads offered back to back while the memory withholds grant.
        step(); drive_req(mk_req(1'b0, 3'd2, 4'd0, 32'h100, 32'd0));
        @(negedge clk); chk1("qf_acc0", data_addr_ok, 1'b1);
        step(); data_addr = 32'h104;
        @(negedge clk); chk1("qf_acc1", data_addr_ok, 1'b1); chk1("qf_req_a", mem_req, 1'b1);
        step(); data_addr = 32'h108;
        @(negedge clk); chk1("qf_full0", data_addr_ok, 1'b0);
        step();
        @(negedge clk); chk1("qf_full1", data_addr_ok, 1'b0); chk("qf_head", mem_addr, 32'h100);
        step(); mem_gnt = 1'b1;
        @(negedge clk); chk1("qf_full2", data_addr_ok, 1'b0);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_AAAA;
        @(negedge clk); chk1("qf_full_pop", data_addr_ok, 1'b0);
`ifndef DREQ_RESP_REG_EN
        chk1("qf_ok_a", data_data_ok, 1'b1); chk("qf_rdata_a", data_rdata, 32'h0000_AAAA);
`endif
        step(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk); chk1("qf_acc2", data_addr_ok, 1'b1);
        chk1("qf_b2b_req", mem_req, 1'b1); chk("qf_head_b", mem_addr, 32'h104);
`ifdef DREQ_RESP_REG_EN
        chk1("qf_ok_a", data_data_ok, 1'b1); chk("qf_rdata_a", data_rdata, 32'h0000_AAAA);
`endif
        step(); data_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); chk1("qf_full3", data_addr_ok, 1'b0); chk1("qf_req_b", mem_req, 1'b1);
        step(); mem_gnt = 1'b0;
        @(negedge clk); chk1("qf_wait_b", mem_req, 1'b0);

        // Reset while waiting on memory with two entries queued; then stray handshakes.
        step(); resetn = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("mr_mem_req", mem_req, 1'b0);
        chk1("mr_data_ok", data_data_ok, 1'b0);
        chk("mr_rdata", data_rdata, 32'd0);
        chk1("mr_addr_ok", data_addr_ok, 1'b1);
        step(); resetn = 1'b1; mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_rvalid = i[0];
            mem_gnt    = ~i[0];
            mem_rdata  = $urandom;
            @(negedge clk);
            chk1("stray_ok", data_data_ok, 1'b0);
            chk1("stray_req", mem_req, 1'b0);
            chk1("stray_addr_ok", data_addr_ok, 1'b1);
        end
        step(); idle_inputs();
        @(negedge clk); chk1("stray_ok_tail", data_data_ok, 1'b0);

        // Ordering with memory latencies 3, 1, 2 and a push landing on a pop.
        clear_model();
        send_q.push_back(mk_req(1'b0, 3'd2, 4'd0, 32'h0000_0A00, 32'd0));
        send_q.push_back(mk_req(1'b0, 3'd2, 4'd0, 32'h0000_0B00, 32'd0));
        send_q.push_back(mk_req(1'b0, 3'd2, 4'd0, 32'h0000_0C00, 32'd0));
        plan_q.push_back(2); plan_q.push_back(0); plan_q.push_back(1);
        run_traffic(100, 60, "ord_drain");

        // Randomized mixed traffic.
        for (int i = 0; i < 120; i++) send_q.push_back(rand_req());
        run_traffic(60, 4000, "rand_drain");
        for (int i = 0; i < 100; i++) send_q.push_back(rand_req());
        run_traffic(95, 4000, "rand_dense_drain");
        repeat (3) auto_cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
